mb_lane_pattern_checker: RTL

Per-lane receive pattern checker for mainband initialization. It compares each data lane against a locally generated PRBS over a fixed number of valid beats and counts per-lane errors. It then produces the 16-bit per-lane pass/fail vector consumed by the functional-lane setup stage. It sits directly upstream of that stage: its result output feeds the setup stage's data-to-clock result input, and its done output gates the setup stage's start.

---
 rtl/mb_lane_pattern_checker.sv | 74 +++++++
 1 files changed

// File: rtl/mb_lane_pattern_checker.sv
// mb_lane_pattern_checker: compares every lane against a shared PRBS over a fixed
// number of valid beats and latches a per-lane pass/fail vector at run completion.
module mb_lane_pattern_checker #(
  parameter int          LANES       = 16,
  parameter int          COMPARE_LEN = 128,
  parameter int          ERR_W       = 8,
  parameter int          ERR_THRESH  = 0,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start_check,
  input  logic             i_abort,
  input  logic             i_rx_valid,
  input  logic [LANES-1:0] i_rx_data,
  output logic [LANES-1:0] o_Transmitter_initiated_Data_to_CLK_Result,
  output logic             o_done_check,
  output logic             o_busy
);
  // one-hot-ish encoding so busy/done come straight off state flops
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] COMPARE = 2'b01;
  localparam logic [1:0] DONE    = 2'b10;
  localparam logic [15:0]      LAST = 16'(COMPARE_LEN - 1);
  localparam logic [ERR_W-1:0] THR  = ERR_W'(ERR_THRESH);

  logic [1:0]       r_state;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_beat;
  logic [ERR_W-1:0] r_cnt [LANES];
  logic [LANES-1:0] r_result;
  logic [ERR_W-1:0] w_cnt [LANES];
  logic [LANES-1:0] w_pass;
  logic             w_beat;

  assign w_beat = (r_state == COMPARE) && i_rx_valid;

  // next counts include the current beat so the last beat's error reaches the result
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_cnt[l]  = r_cnt[l] + ERR_W'((i_rx_data[l] != r_lfsr[15]) && !(&r_cnt[l]));
      w_pass[l] = w_cnt[l] <= THR;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lfsr   <= SEED;
      r_beat   <= '0;
      r_result <= '0;
      for (int l = 0; l < LANES; l++) r_cnt[l] <= '0;
    end else if (i_abort) begin
      r_state <= IDLE;
    end else if (start_check) begin
      r_state <= COMPARE;
      r_lfsr  <= SEED;
      r_beat  <= '0;
      for (int l = 0; l < LANES; l++) r_cnt[l] <= '0;
    end else if (w_beat) begin
      for (int l = 0; l < LANES; l++) r_cnt[l] <= w_cnt[l];
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_beat <= r_beat + 16'd1;
      if (r_beat == LAST) begin
        r_state  <= DONE;
        r_result <= w_pass;
      end
    end
  end

  assign o_busy                                     = r_state[0];
  assign o_done_check                               = r_state[1];
  assign o_Transmitter_initiated_Data_to_CLK_Result = r_result;
endmodule
